// File: rtl/fir_tdm_mac.sv
// Time-multiplexed multi-channel FIR: one shared signed MAC walks TAPS x CHANNELS products per frame strobe.
// Optional FIR_SAT_EN: saturate at channel-end quantisation instead of wrapping.
module fir_tdm_mac #(
    parameter int TAPS     = 51,
    parameter int CHANNELS = 2,
    parameter int L        = 24,
    parameter int K        = 24,
    parameter int M        = 16,
    parameter int A        = 46,
    parameter int O        = 41
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  next_lrclk_fall,
    input  logic [CHANNELS*L-1:0] x_in,
    input  logic [TAPS*M-1:0]     b,
    output logic [CHANNELS*K-1:0] y_out,
    output logic                  y_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int PW = $clog2(TAPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int P  = L + M;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_nxt;

    logic [PW-1:0]       wp;
    logic [PW-1:0]       rp;
    logic [PW-1:0]       k;
    logic [CW-1:0]       c;
    logic signed [L-1:0] hist [CHANNELS][TAPS];
    logic [K-1:0]        hold [CHANNELS];
    logic signed [A-1:0] acc;
    logic                y_valid_q;

    logic                capture;
    logic                mac_step;
    logic                publish;
    logic                overrun_set;
    logic                chan_end;
    logic                last_chan;

    logic signed [L-1:0] sample;
    logic signed [M-1:0] coef;
    logic signed [P-1:0] prod;
    logic [A-1:0]        acc_sum;
    logic [K-1:0]        quant;

    assign chan_end  = (k == PW'(TAPS - 1));
    assign last_chan = (c == CW'(CHANNELS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (next_lrclk_fall) state_nxt = MAC;
            MAC:     if (chan_end && last_chan) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        mac_step    = 1'b0;
        publish     = 1'b0;
        busy        = 1'b1;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                capture = ena & next_lrclk_fall;
            end
            MAC: begin
                mac_step    = ena;
                overrun_set = ena & next_lrclk_fall;
            end
            DONE: begin
                publish     = ena;
                overrun_set = ena & next_lrclk_fall;
            end
            default: busy = 1'b0;
        endcase
    end

    // rp starts on the newest sample and walks backwards; TAPS steps bring it home for the next channel
    assign sample  = hist[c][rp];
    assign coef    = $signed(b[k*M +: M]);
    assign prod    = sample * coef;
    assign acc_sum = acc + {{(A-P){prod[P-1]}}, prod};

    always_comb begin
        quant = acc_sum[O-1:O-K];
`ifdef FIR_SAT_EN
        if (!((&acc_sum[A-1:O-1]) || !(|acc_sum[A-1:O-1]))) begin
            quant = acc_sum[A-1] ? {1'b1, {(K-1){1'b0}}} : {1'b0, {(K-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            k         <= '0;
            c         <= '0;
            acc       <= '0;
            y_out     <= '0;
            y_valid_q <= 1'b0;
            overrun   <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hold[ch] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    hist[ch][t] <= '0;
                end
            end
        end else if (ena) begin
            y_valid_q <= publish;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
            if (capture) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    hist[ch][wp] <= x_in[ch*L +: L];
                end
                wp  <= (wp == PW'(TAPS - 1)) ? '0 : wp + 1'b1;
                rp  <= wp;
                k   <= '0;
                c   <= '0;
                acc <= '0;
            end
            if (mac_step) begin
                rp <= (rp == '0) ? PW'(TAPS - 1) : rp - 1'b1;
                if (chan_end) begin
                    hold[c] <= quant;
                    acc     <= '0;
                    k       <= '0;
                    c       <= c + 1'b1;
                end else begin
                    acc <= acc_sum;
                    k   <= k + 1'b1;
                end
            end
            if (publish) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    y_out[ch*K +: K] <= hold[ch];
                end
            end
        end
    end

    // A pending pulse survives an ena dropout and reappears once ena returns
    assign y_valid = y_valid_q & ena;

endmodule

// File: doc/fir_tdm_mac.md
# fir_tdm_mac

Time-multiplexed, multi-channel successor to the fully-parallel tapped-delay FIR. One signed multiplier-accumulator is shared across all taps and all channels. Per-channel sample history lives in circular register buffers. On each audio-frame strobe the block captures one sample per channel, runs TAPS×CHANNELS MAC cycles, then presents all channel outputs together with a one-cycle valid pulse. It sits between the I2S receive deserialiser and the transmit serialiser in the audio path.

## Interface
- TAPS, 51: coefficient count (filter order + 1), ≥2
- CHANNELS, 2: independent channels sharing one coefficient set, ≥1
- L, 24: input sample width, signed
- K, 24: output sample width, signed
- M, 16: coefficient width, signed
- A, 46: accumulator width; A ≥ L+M+clog2(TAPS)
- O, 41: output slice top; output = acc[O-1:O-K]; O ≤ A, O ≥ K
- clk  in  1  system clock (divided clock, same as rest of audio path)
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- ena  in  1  global enable; low freezes all state
- next_lrclk_fall  in  1  frame strobe, one clk wide
- x_in  in  CHANNELS*L  packed samples, channel c at [c*L +: L]
- b  in  TAPS*M  packed coefficients, tap k at [k*M +: M]; static during a run
- y_out  out  CHANNELS*K  packed results, channel c at [c*K +: K]
- y_valid  out  1  one-cycle pulse on y_out update
- busy  out  1  high while not IDLE
- overrun  out  1  sticky: strobe arrived while busy

## Operation
- Reset values: y_out=0, y_valid=0, busy=0, overrun=0, every history entry = 0, write pointer = 0, accumulator = 0, state IDLE.
- The FSM has three states: IDLE → MAC → DONE → IDLE.
- IDLE:
  - Strobe sampled high with ena=1: write x_in channel c into hist[c][wp].
  - Advance wp, wrapping TAPS-1 → 0.
  - Clear tap index k=0, channel index c=0, and the accumulator; go to MAC.
- MAC, one multiply-accumulate per cycle:
  - acc += b[k] * hist[c][(wp_new - 1 - k) mod TAPS].
  - Tap 0 therefore multiplies the newest sample.
  - Products are full-precision L+M bits, sign-extended to A bits.
- Channel end (k=TAPS-1):
  - Quantise (acc + product) and store it in hold[c].
  - Clear acc, set k=0, increment c.
  - After the last channel, go to DONE.
- DONE: copy hold to y_out, pulse y_valid, return to IDLE.
- Quantisation without saturation: two's-complement truncation of the slice acc[O-1:O-K]; upper bits are discarded (wrap).
- ena=0: state, indices, acc, buffers and outputs hold. y_valid is forced 0 and resumes its pending pulse when ena returns. Strobes are ignored.
- A strobe while busy (MAC or DONE) is ignored: no capture, run unaffected, overrun set to 1. It clears only on reset.
- Reset mid-run aborts immediately: no y_valid, y_out=0, history cleared.
- Channels are fully independent. Coefficients are shared by all channels.

## Timing
- Let N be the capture edge in IDLE.
- MACs occupy edges N+1 … N+TAPS*CHANNELS.
- y_out updates and y_valid is high in the cycle after edge N+TAPS*CHANNELS+1.
- Latency: TAPS*CHANNELS+1 clk edges from capture to output.
- busy is high from the cycle after edge N through edge N+TAPS*CHANNELS+1; it is low again in the same cycle y_valid is high.
- Minimum strobe spacing: TAPS*CHANNELS+2 clk cycles.
  - A strobe coinciding with y_valid (state IDLE) is accepted.
  - A strobe one cycle earlier sets overrun.
- y_out is stable between y_valid pulses. All channels change on the same edge.

## Configuration
- FIR_SAT_EN defined:
  - Channel-end quantisation saturates.
  - If acc[A-1:O-1] is not all-equal, output 2^(K-1)-1 for a positive acc or -2^(K-1) for a negative acc.
  - Otherwise output the slice.
- FIR_SAT_EN undefined: plain truncation/wrap as in Operation. No saturation logic is generated.

## Test plan
- Impulse, TAPS=4, CHANNELS=2, b={1,2,3,4}·2^(O-L-... )=unit-scaled, ch0 x=1 then 0s → four outputs follow b exactly; ch1 stays 0 throughout.
- Stereo independence: ch0=+1000 constant, ch1=-1000 constant, all-ones b → steady state ch0=+1000·TAPS·scale and ch1=-1000·TAPS·scale. y_valid arrives TAPS*CHANNELS+1 edges after each strobe.
- Overrun: second strobe 5 cycles after the first → overrun=1, exactly one y_valid, history advanced once. A strobe on the y_valid cycle is accepted with no new overrun.
- Reset mid-MAC (rst=0 at edge N+3) → y_valid never pulses, y_out=0, busy=0. The next impulse response matches a clean start.
- ena low for 10 cycles mid-run → y_valid is delayed by exactly 10 cycles with an identical y_out. The strobe during the freeze is ignored and overrun stays 0.
- Saturation, with x=max positive and b=max positive: FIR_SAT_EN defined → y_out=0x7FFFFF. Undefined → the wrapped slice value.
